// File: rtl/alu_share_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter_if
//   Bundles the request and response channels of the two ALU requesters.
//   The requesters drive the "master" side and the arbiter uses the "slave"
//   side.
//
//   Signals (bit / index i = requester i):
//     req_valid[1:0]      requester has an operation to issue
//     req_ready[1:0]      arbiter accepts the request this cycle
//     reqN_a, reqN_b      32-bit SrcA / SrcB operands
//     reqN_shamt          5-bit shift amount
//     reqN_ctrl           8-bit ALU op code (`aluXxx)
//     resp_valid[1:0]     result buffer i holds an undelivered result
//     resp_ready[1:0]     requester i consumes its result this cycle
//     respN_result        buffered ALU result
//     respN_zero          buffered zero flag
//     grant[1:0]          one-hot winner of this cycle (0 when none)
// ----------------------------------------------------------------------------
interface alu_share_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a;
    logic [31:0] req1_a;
    logic [31:0] req0_b;
    logic [31:0] req1_b;
    logic [4:0]  req0_shamt;
    logic [4:0]  req1_shamt;
    logic [7:0]  req0_ctrl;
    logic [7:0]  req1_ctrl;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp0_result;
    logic [31:0] resp1_result;
    logic        resp0_zero;
    logic        resp1_zero;
    logic [1:0]  grant;

    modport master (
        output req_valid, req0_a, req1_a, req0_b, req1_b,
               req0_shamt, req1_shamt, req0_ctrl, req1_ctrl, resp_ready,
        input  req_ready, resp_valid, resp0_result, resp1_result,
               resp0_zero, resp1_zero, grant
    );

    modport slave (
        input  req_valid, req0_a, req1_a, req0_b, req1_b,
               req0_shamt, req1_shamt, req0_ctrl, req1_ctrl, resp_ready,
        output req_ready, resp_valid, resp0_result, resp1_result,
               resp0_zero, resp1_zero, grant
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational ALU between two requesters (e.g. the EX stage
//   and an iterative mult/div/branch-compare helper). Round-robin arbitration,
//   one accept per cycle, result registered into a one-entry buffer per
//   requester (request-to-resp_valid latency of one cycle).
//
//   Ports:
//     clk        system clock, rising edge
//     reset      synchronous, active-high reset
//     bus        alu_share_arbiter_if.slave (request/response channels, grant)
//   Optional ports (macro ALU_ARB_STATS_EN defined):
//     gnt_cnt0   saturating count of accepts for requester 0
//     gnt_cnt1   saturating count of accepts for requester 1
//     stall_cnt  saturating count of cycles where some valid request was
//                not accepted
//
//   Parameter:
//     CNT_W      width of the statistics counters
//
//   Build option: define ALU_ARB_STATS_EN to add the statistics counters.
// ----------------------------------------------------------------------------

`ifndef aluAdd
`define aluAdd 8'h00
`define aluSub 8'h01
`define aluAnd 8'h02
`define aluOr  8'h03
`define aluXor 8'h04
`define aluNor 8'h05
`define aluSll 8'h06
`define aluSrl 8'h07
`define aluSra 8'h08
`define aluEq  8'h09
`define aluLt  8'h0A
`define aluLe  8'h0B
`define aluGt  8'h0C
`define aluGe  8'h0D
`endif

module alu_share_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_share_arbiter_if.slave     bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]       gnt_cnt0,
    output logic [CNT_W-1:0]       gnt_cnt1,
    output logic [CNT_W-1:0]       stall_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    // ------------------------------------------------------------------
    // Shared ALU. Shifts operate on SrcB; compares are unsigned and
    // return 0/1. Unknown op codes yield 0, so zero comes out as 1.
    // ------------------------------------------------------------------
    function automatic logic [31:0] alu_eval(
        input logic [7:0]  ctrl,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [4:0]  shamt
    );
        logic [31:0] r;
        r = 32'd0;
        case (ctrl)
            `aluAdd: r = a + b;
            `aluSub: r = a - b;
            `aluAnd: r = a & b;
            `aluOr:  r = a | b;
            `aluXor: r = a ^ b;
            `aluNor: r = ~(a | b);
            `aluSll: r = b << shamt;
            `aluSrl: r = b >> shamt;
            `aluSra: r = $unsigned($signed(b) >>> shamt);
            `aluEq:  r = {31'd0, (a == b)};
            `aluLt:  r = {31'd0, (a <  b)};
            `aluLe:  r = {31'd0, (a <= b)};
            `aluGt:  r = {31'd0, (a >  b)};
            `aluGe:  r = {31'd0, (a >= b)};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    logic [1:0]  resp_valid_q;
    logic [31:0] result0_q;
    logic [31:0] result1_q;
    logic        zero0_q;
    logic        zero1_q;
    logic        last_grant_q;

    logic [1:0]  slot_free;
    logic [1:0]  eligible;
    logic [1:0]  grant_c;

    logic [7:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_zero;

    // A slot is free when empty or when its result is drained this cycle,
    // which lets a requester refill its buffer back-to-back.
    always_comb begin
        slot_free = ~resp_valid_q | bus.resp_ready;
        eligible  = bus.req_valid & slot_free;
        grant_c   = 2'b00;
        if (!reset) begin
            if (eligible == 2'b11) begin
                // Priority goes to whoever did not win last.
                grant_c = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant_c = eligible;
            end
        end
    end

    always_comb begin
        alu_ctrl  = bus.req0_ctrl;
        alu_a     = bus.req0_a;
        alu_b     = bus.req0_b;
        alu_shamt = bus.req0_shamt;
        if (grant_c[1]) begin
            alu_ctrl  = bus.req1_ctrl;
            alu_a     = bus.req1_a;
            alu_b     = bus.req1_b;
            alu_shamt = bus.req1_shamt;
        end
    end

    assign alu_result = alu_eval(alu_ctrl, alu_a, alu_b, alu_shamt);
    assign alu_zero   = (alu_result == 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 2'b00;
            result0_q    <= 32'd0;
            result1_q    <= 32'd0;
            zero0_q      <= 1'b0;
            zero1_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            // A new accept wins over a same-cycle drain: buffer stays full.
            resp_valid_q[0] <= grant_c[0] | (resp_valid_q[0] & ~bus.resp_ready[0]);
            resp_valid_q[1] <= grant_c[1] | (resp_valid_q[1] & ~bus.resp_ready[1]);
            if (grant_c[0]) begin
                result0_q <= alu_result;
                zero0_q   <= alu_zero;
            end
            if (grant_c[1]) begin
                result1_q <= alu_result;
                zero1_q   <= alu_zero;
            end
            if (|grant_c) begin
                last_grant_q <= grant_c[1];
            end
        end
    end

    assign bus.grant        = grant_c;
    assign bus.req_ready    = grant_c;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp0_result = result0_q;
    assign bus.resp1_result = result1_q;
    assign bus.resp0_zero   = zero0_q;
    assign bus.resp1_zero   = zero1_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] gnt_cnt0_q;
    logic [CNT_W-1:0] gnt_cnt1_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             stall_c;

    assign stall_c = |(bus.req_valid & ~grant_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt0_q  <= '0;
            gnt_cnt1_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (grant_c[0] && (gnt_cnt0_q != '1)) begin
                gnt_cnt0_q <= gnt_cnt0_q + 1'b1;
            end
            if (grant_c[1] && (gnt_cnt1_q != '1)) begin
                gnt_cnt1_q <= gnt_cnt1_q + 1'b1;
            end
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign gnt_cnt0  = gnt_cnt0_q;
    assign gnt_cnt1  = gnt_cnt1_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
`ifndef aluAdd
`define aluAdd 8'h00
`define aluSub 8'h01
`define aluAnd 8'h02
`define aluOr  8'h03
`define aluXor 8'h04
`define aluNor 8'h05
`define aluSll 8'h06
`define aluSrl 8'h07
`define aluSra 8'h08
`define aluEq  8'h09
`define aluLt  8'h0A
`define aluLe  8'h0B
`define aluGt  8'h0C
`define aluGe  8'h0D
`endif

module tb_alu_share_arbiter;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    alu_share_arbiter_if bus();

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;
    logic [CNT_W-1:0] stall_cnt;
`endif

    alu_share_arbiter #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef ALU_ARB_STATS_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference ALU, returns {zero, result}.
    function automatic logic [32:0] ref_alu(input logic [7:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] s);
        logic [31:0] r;
        case (c)
            `aluAdd: r = a + b;
            `aluSub: r = a - b;
            `aluAnd: r = a & b;
            `aluOr:  r = a | b;
            `aluXor: r = a ^ b;
            `aluNor: r = ~(a | b);
            `aluSll: r = b << s;
            `aluSrl: r = b >> s;
            `aluSra: r = (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            `aluEq:  r = (a == b) ? 32'd1 : 32'd0;
            `aluLt:  r = (a <  b) ? 32'd1 : 32'd0;
            `aluLe:  r = (a <= b) ? 32'd1 : 32'd0;
            `aluGt:  r = (a >  b) ? 32'd1 : 32'd0;
            `aluGe:  r = (a >= b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    // Scoreboard: one queue of expected {zero,result} per requester.
    // A non-empty queue means the model's result buffer is occupied.
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    bit          m_last = 1'b1;
    logic [CNT_W-1:0] m_g0 = '0;
    logic [CNT_W-1:0] m_g1 = '0;
    logic [CNT_W-1:0] m_st = '0;

    function logic [1:0] model_grant();
        logic [1:0] elig;
        if (reset) return 2'b00;
        elig[0] = bus.req_valid[0] && (q0.size() == 0 || bus.resp_ready[0]);
        elig[1] = bus.req_valid[1] && (q1.size() == 0 || bus.resp_ready[1]);
        if (elig == 2'b11) return m_last ? 2'b01 : 2'b10;
        return elig;
    endfunction

    // Model update at each edge: issue accepted requests into the scoreboard.
    always @(posedge clk) begin : model_proc
        logic [1:0] g;
        if (reset) begin
            q0.delete();
            q1.delete();
            m_last = 1'b1;
            m_g0 = '0;
            m_g1 = '0;
            m_st = '0;
        end else begin
            g = model_grant();
            if (g[0]) q0.push_back(ref_alu(bus.req0_ctrl, bus.req0_a, bus.req0_b, bus.req0_shamt));
            if (g[1]) q1.push_back(ref_alu(bus.req1_ctrl, bus.req1_a, bus.req1_b, bus.req1_shamt));
            if (g != 2'b00) m_last = g[1];
            if (g[0] && m_g0 != '1) m_g0 = m_g0 + 1'b1;
            if (g[1] && m_g1 != '1) m_g1 = m_g1 + 1'b1;
            if (((bus.req_valid & ~g) != 2'b00) && m_st != '1) m_st = m_st + 1'b1;
        end
    end

    // Monitor: compares DUT outputs mid-cycle and pops delivered results.
    always @(negedge clk) begin : monitor_proc
        logic [32:0] e;
        logic [1:0]  g;
        g = model_grant();
        chk("grant", 64'(bus.grant), 64'(g));
        chk("req_ready", 64'(bus.req_ready), 64'(g));
        chk("resp_valid", 64'(bus.resp_valid), 64'({q1.size() != 0, q0.size() != 0}));
        if (bus.resp_valid[0] && bus.resp_ready[0]) begin
            if (q0.size() == 0) chk("resp0_unexpected", 64'(1), 64'(0));
            else begin
                e = q0.pop_front();
                chk("resp0", 64'({bus.resp0_zero, bus.resp0_result}), 64'(e));
            end
        end else if (q0.size() != 0 && bus.resp_ready[0]) begin
            void'(q0.pop_front());
        end
        if (bus.resp_valid[1] && bus.resp_ready[1]) begin
            if (q1.size() == 0) chk("resp1_unexpected", 64'(1), 64'(0));
            else begin
                e = q1.pop_front();
                chk("resp1", 64'({bus.resp1_zero, bus.resp1_result}), 64'(e));
            end
        end else if (q1.size() != 0 && bus.resp_ready[1]) begin
            void'(q1.pop_front());
        end
`ifdef ALU_ARB_STATS_EN
        chk("gnt_cnt0", 64'(gnt_cnt0), 64'(m_g0));
        chk("gnt_cnt1", 64'(gnt_cnt1), 64'(m_g1));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_st));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [7:0] c,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
        if (i == 0) begin
            bus.req_valid[0] = v; bus.req0_ctrl = c; bus.req0_a = a;
            bus.req0_b = b; bus.req0_shamt = s;
        end else begin
            bus.req_valid[1] = v; bus.req1_ctrl = c; bus.req1_a = a;
            bus.req1_b = b; bus.req1_shamt = s;
        end
    endtask

    task automatic rand_req(input int i);
        logic [7:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        c = ($urandom_range(0, 15) == 15) ? 8'($urandom) : 8'($urandom_range(0, 13));
        a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
        b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
        set_req(i, ($urandom_range(0, 2) != 0), c, a, b, 5'($urandom));
    endtask

    initial begin : stim
        logic [1:0] acc;
        logic       rs;
        set_req(0, 0, 8'h00, 0, 0, 0);
        set_req(1, 0, 8'h00, 0, 0, 0);
        bus.resp_ready = 2'b00;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;

        // Single request, one-cycle latency.
        bus.resp_ready = 2'b11;
        set_req(0, 1, `aluAdd, 5, 3, 0);
        @(negedge clk); chk("t1_grant", 64'(bus.grant), 64'(2'b01));
        step();
        set_req(0, 0, `aluAdd, 5, 3, 0);
        @(negedge clk);
        chk("t1_resp_valid", 64'(bus.resp_valid), 64'(2'b01));
        chk("t1_result", 64'({bus.resp0_zero, bus.resp0_result}), 64'({1'b0, 32'd8}));
        step();
        reset = 1'b1; step(); reset = 1'b0;

        // Both valid: round-robin starting at requester 0.
        set_req(0, 1, `aluSub, 7, 7, 0);
        set_req(1, 1, `aluSll, 0, 1, 4);
        @(negedge clk); chk("t2_grant0", 64'(bus.grant), 64'(2'b01));
        step();
        @(negedge clk); chk("t2_grant1", 64'(bus.grant), 64'(2'b10));
        chk("t2_resp0", 64'({bus.resp0_zero, bus.resp0_result}), 64'({1'b1, 32'd0}));
        step();
        set_req(0, 0, `aluSub, 7, 7, 0);
        set_req(1, 0, `aluSll, 0, 1, 4);
        @(negedge clk);
        chk("t2_resp1", 64'({bus.resp1_zero, bus.resp1_result}), 64'({1'b0, 32'd16}));
        step();

        // Continuous contention alternates.
        set_req(0, 1, `aluAdd, 1, 1, 0);
        set_req(1, 1, `aluAdd, 2, 2, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t3_alternate", 64'(bus.grant), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
            step();
        end
        set_req(0, 0, `aluAdd, 0, 0, 0);
        set_req(1, 0, `aluAdd, 0, 0, 0);
        step();

        // Backpressure on requester 0, requester 1 proceeds.
        bus.resp_ready = 2'b00;
        set_req(0, 1, `aluOr, 32'hF0, 32'h0F, 0);
        @(negedge clk); chk("t4_grant_or", 64'(bus.grant), 64'(2'b01));
        step();
        set_req(0, 1, `aluXor, 1, 1, 0);
        set_req(1, 1, `aluLt, 2, 3, 0);
        @(negedge clk);
        chk("t4_req_ready", 64'(bus.req_ready), 64'(2'b10));
        chk("t4_hold", 64'(bus.resp0_result), 64'(32'hFF));
        step();
        set_req(1, 0, `aluLt, 2, 3, 0);
        bus.resp_ready = 2'b01;
        @(negedge clk); chk("t4_refill_grant", 64'(bus.grant), 64'(2'b01));
        step();
        set_req(0, 0, `aluXor, 1, 1, 0);
        @(negedge clk);
        chk("t4_resp0", 64'({bus.resp_valid[0], bus.resp0_zero, bus.resp0_result}),
            64'({1'b1, 1'b1, 32'd0}));
        chk("t4_resp1", 64'(bus.resp1_result), 64'(32'd1));
        step();
        bus.resp_ready = 2'b11;
        step();

        // Unknown op code, arithmetic shift.
        set_req(1, 1, 8'hFF, 1, 1, 0);
        @(negedge clk); chk("t5_grant", 64'(bus.grant), 64'(2'b10));
        step();
        set_req(1, 1, `aluSra, 0, 32'h8000_0000, 4);
        @(negedge clk);
        chk("t5_unknown", 64'({bus.resp1_zero, bus.resp1_result}), 64'({1'b1, 32'd0}));
        step();
        set_req(1, 0, `aluSra, 0, 0, 0);
        @(negedge clk);
        chk("t5_sra", 64'(bus.resp1_result), 64'(32'hF800_0000));
        step();

        // Reset right after a grant, slots full.
        bus.resp_ready = 2'b00;
        set_req(0, 1, `aluAdd, 1, 2, 0);
        step();
        reset = 1'b1;
        set_req(1, 1, `aluAdd, 3, 4, 0);
        @(negedge clk); chk("t6_grant_in_reset", 64'(bus.grant), 64'(2'b00));
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_resp_valid", 64'(bus.resp_valid), 64'(2'b00));
        chk("t6_results", 64'({bus.resp0_zero, bus.resp0_result, bus.resp1_zero, bus.resp1_result}),
            64'(0));
        chk("t6_first_grant", 64'(bus.grant), 64'(2'b01));
`ifdef ALU_ARB_STATS_EN
        chk("t6_counters", 64'({gnt_cnt0, gnt_cnt1, stall_cnt}), 64'(0));
`endif
        step();
        set_req(0, 0, `aluAdd, 0, 0, 0);
        set_req(1, 0, `aluAdd, 0, 0, 0);
        bus.resp_ready = 2'b11;
        repeat (2) step();

        // Randomized traffic; unaccepted requests are held stable.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            rs  = reset;
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 199) == 0);
            if (!bus.req_valid[0] || acc[0] || rs) rand_req(0);
            if (!bus.req_valid[1] || acc[1] || rs) rand_req(1);
            bus.resp_ready = 2'($urandom);
        end
        reset = 1'b0;
        set_req(0, 0, 8'h00, 0, 0, 0);
        set_req(1, 0, 8'h00, 0, 0, 0);
        bus.resp_ready = 2'b11;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one instance of the combinational ALU between two requesters, e.g. the EX stage and an iterative mult/div/branch-compare helper. Each requester has a valid/ready request channel and a valid/ready response channel with a one-entry result buffer. Arbitration is round-robin. Operation codes are the `aluXxx macros from define.v, and results are registered, giving 1-cycle latency.

Parameters:
CNT_W, 16, width of the optional grant/stall statistics counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  2  per-requester request valid, bit i = requester i
req_ready  output  2  per-requester request accepted this cycle
req0_a / req1_a  input  32  SrcA operand
req0_b / req1_b  input  32  SrcB operand
req0_shamt / req1_shamt  input  5  shift amount
req0_ctrl / req1_ctrl  input  8  ALU op code (`aluAdd … `aluGe)
resp_valid  output  2  result buffer i holds an undelivered result
resp_ready  input  2  requester i consumes its result this cycle
resp0_result / resp1_result  output  32  buffered ALUResult
resp0_zero / resp1_zero  output  1  buffered zero flag
grant  output  2  one-hot, the requester accepted this cycle (0 if none)

Behaviour:
- Slot i is free when resp_valid[i]==0, or when resp_valid[i]&&resp_ready[i] in the same cycle (drain-and-refill allowed).
- Eligible[i] = req_valid[i] && slot i free.
- Round-robin:
  - Register last_grant (1 bit). Priority goes to the requester != last_grant.
  - If only one requester is eligible, it wins.
  - At most one grant per cycle.
- req_ready[i] = grant[i]; all three are combinational from the current inputs and state. The accept handshake is req_valid[i]&&req_ready[i].
- On accept of requester i at edge N:
  - Operands are muxed into the ALU, and ALUResult/zero are captured into slot i.
  - resp_valid[i]=1 from cycle N+1.
  - last_grant<=i.
  - Latency: request to resp_valid is 1 cycle.
- resp_valid[i] stays high, with result and zero stable, until resp_ready[i] is sampled high. It then clears, unless a new accept for i occurs in the same cycle; in that case it stays 1 and the data is replaced.
- Requesters must hold request fields stable while valid && !ready. The arbiter does not latch unaccepted requests.
- An ineligible requester (slot full, not draining) is never granted, and the other requester may proceed. There is no head-of-line blocking between requesters.
- The ALU function matches the codebase ALU:
  - Add, sub, and, or, xor, nor.
  - sll/srl/sra use shamt on SrcB.
  - eq/lt/le/gt/ge are unsigned compares returning 0/1.
  - An unknown code gives result 0 and zero=1.
  - All arithmetic is 32-bit modulo; there is no overflow flag.
- Reset (synchronous, any cycle, including with slots full or a grant pending):
  - resp_valid=0, both results=0, both zero=0, last_grant=1 (requester 0 wins first).
  - All in-flight results are discarded.
  - grant/req_ready are 0 during the reset cycle.
- Idle (no req_valid): grant=0, and state holds.

Optional Feature:
Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs gnt_cnt0, gnt_cnt1 (CNT_W), each incremented on an accept for that requester.
  - Adds stall_cnt (CNT_W), incremented each cycle some req_valid[i]=1 and req_ready[i]=0 (once per cycle max).
  - All counters saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- After reset, req0 valid only, `aluAdd, a=5, b=3, resp_ready=2'b11 → grant=01 same cycle; next cycle resp_valid=01, resp0_result=8, resp0_zero=0.
- Both valid, req0 `aluSub 7-7, req1 `aluSll b=1 shamt=4, held for 2 cycles → cycle 0 grant=01, cycle 1 grant=10; resp0 = 0/zero=1, resp1 = 16/zero=0.
- Both continuously valid with resp_ready=11 for 6 cycles → grant alternates 01,10,01,10,01,10.
- Backpressure: resp_ready=00, req0 `aluOr 0xF0|0x0F accepted; req0 re-asserted with `aluXor 1^1 → req_ready[0]=0 and resp0_result holds 0xFF. Meanwhile req1 `aluLt 2<3 is granted → resp1_result=1. Raise resp_ready[0] → the pending req0 is accepted that cycle, and the next cycle resp0_result=0, zero=1, resp_valid[0] still 1.
- Unknown ctrl 8'hFF on req1, a=b=1 → resp1_result=0, zero=1. Then `aluSra b=0x80000000 shamt=4 → 0xF8000000.
- Reset asserted the cycle after a grant with resp_ready=00 → resp_valid=00 and results 0 next cycle. With both requesters then valid, requester 0 is granted first. With ALU_ARB_STATS_EN, all counters read 0.
